// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock time-keeping blocks.
//   timer_state_t    : countdown timer FSM encoding (2 bits)
//   BCD_MAX_ONES     : wrap/clamp value for ones digits and minute tens (9)
//   BCD_MAX_SEC_TENS : wrap/clamp value for the seconds tens digit (5)
//   bcd_clamp()      : saturate a raw load digit to a legal maximum
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_t;

  localparam logic [3:0] BCD_MAX_ONES     = 4'd9;
  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic [3:0] max_v);
    return (d > max_v) ? max_v : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counting chain.
//   in_clk   : clock
//   rst      : synchronous active-low reset (digit -> 0)
//   load     : load ld_val (takes precedence over dec)
//   ld_val   : already-clamped value to load
//   dec      : decrement by one; 0 wraps to wrap_val (borrow handled by caller)
//   wrap_val : value loaded when decrementing from 0 (9 or 5)
//   q        : current digit
//   zero     : q == 0, used by the caller to build the borrow chain
module bcd_digit_down
  import clock_pkg::*;
(
  input  logic       in_clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       dec,
  input  logic [3:0] wrap_val,
  output logic [3:0] q,
  output logic       zero
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)
      q_d = ld_val;
    else if (dec)
      q_d = (q_q == 4'd0) ? wrap_val : q_q - 4'd1;
  end

  always_ff @(posedge in_clk) begin
    if (!rst) q_q <= 4'd0;
    else      q_q <= q_d;
  end

  assign q    = q_q;
  assign zero = (q_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with alarm.
//   in_clk, rst            : clock, synchronous active-low reset
//   tick                   : 1 Hz enable, one cycle wide
//   load, ld_*             : load strobe and raw BCD digits (clamped here)
//   start_stop, ack        : command pulses (run/pause toggle, alarm ack)
//   min_t..sec_o           : current value
//   running / alarm / done : state RUN / state EXPIRED / one-cycle expiry pulse
module countdown_timer
  import clock_pkg::*;
(
  input  logic       in_clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] ld_min_t,
  input  logic [3:0] ld_min_o,
  input  logic [3:0] ld_sec_t,
  input  logic [3:0] ld_sec_o,
  input  logic       start_stop,
  input  logic       ack,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       alarm,
  output logic       done
);

  timer_state_t state_q, state_d;
  logic         running_q, running_d;
  logic         alarm_q, alarm_d;
  logic         done_q, done_d;

  // digit index: 0 = sec_o, 1 = sec_t, 2 = min_o, 3 = min_t
  logic [3:0][3:0] dig_q;
  logic [3:0][3:0] ld_val;
  logic [3:0]      zero;
  logic [3:0]      dec;
  logic            dig_load;
  logic            tick_dec;
  logic            all_zero;
  logic            expiring;

  // Load is ignored while running; elsewhere it overrides every other command.
  assign dig_load = load && (state_q != ST_RUN);
  // start_stop in the same cycle as a tick pauses and drops the tick.
  assign tick_dec = tick && (state_q == ST_RUN) && !start_stop && !all_zero;
  assign all_zero = &zero;
  // The tick that takes 00:01 to 00:00 is the expiring one.
  assign expiring = tick_dec && (&zero[3:1]) && (dig_q[0] == 4'd1);

  always_comb begin
    ld_val[0] = bcd_clamp(ld_sec_o, BCD_MAX_ONES);
    ld_val[1] = bcd_clamp(ld_sec_t, BCD_MAX_SEC_TENS);
    ld_val[2] = bcd_clamp(ld_min_o, BCD_MAX_ONES);
    ld_val[3] = bcd_clamp(ld_min_t, BCD_MAX_ONES);
  end

  // Borrow chain: a digit decrements when every lower digit is wrapping from 0.
  always_comb begin
    dec = {tick_dec & (&zero[2:0]),
           tick_dec & (&zero[1:0]),
           tick_dec & zero[0],
           tick_dec};
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dig
      localparam logic [3:0] WRAP = (gi == 1) ? BCD_MAX_SEC_TENS : BCD_MAX_ONES;
      bcd_digit_down u_dig (
        .in_clk   (in_clk),
        .rst      (rst),
        .load     (dig_load),
        .ld_val   (ld_val[gi]),
        .dec      (dec[gi]),
        .wrap_val (WRAP),
        .q        (dig_q[gi]),
        .zero     (zero[gi])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge in_clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load)                        state_d = ST_IDLE;
        else if (start_stop && !all_zero) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_stop)    state_d = ST_PAUSE;
        else if (expiring) state_d = ST_EXPIRED;
      end
      ST_PAUSE: begin
        if (load)            state_d = ST_IDLE;
        else if (start_stop) state_d = ST_RUN;
      end
      ST_EXPIRED: begin
        if (load || ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs, registered alongside the state so they change on the same edge.
  always_comb begin
    running_d = (state_d == ST_RUN);
    alarm_d   = (state_d == ST_EXPIRED);
    done_d    = expiring && (state_d == ST_EXPIRED);
  end

  always_ff @(posedge in_clk) begin
    if (!rst) begin
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      running_q <= running_d;
      alarm_q   <= alarm_d;
      done_q    <= done_d;
    end
  end

  assign sec_o   = dig_q[0];
  assign sec_t   = dig_q[1];
  assign min_o   = dig_q[2];
  assign min_t   = dig_q[3];
  assign running = running_q;
  assign alarm   = alarm_q;
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  logic       in_clk = 1'b0;
  logic       rst, tick, load, start_stop, ack;
  logic [3:0] ld_min_t, ld_min_o, ld_sec_t, ld_sec_o;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic       running, alarm, done;

  int errors = 0;
  int checks = 0;

  countdown_timer dut (
    .in_clk(in_clk), .rst(rst), .tick(tick), .load(load),
    .ld_min_t(ld_min_t), .ld_min_o(ld_min_o), .ld_sec_t(ld_sec_t), .ld_sec_o(ld_sec_o),
    .start_stop(start_stop), .ack(ack),
    .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
    .running(running), .alarm(alarm), .done(done)
  );

  always #5 in_clk = ~in_clk;

  function automatic logic [15:0] val();
    return {min_t, min_o, sec_t, sec_o};
  endfunction

  // Inputs change #1 after the rising edge; outputs are sampled there too.
  task automatic cyc();
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    {ld_min_t, ld_min_o, ld_sec_t, ld_sec_o} = v;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_ss();
    start_stop = 1'b1; cyc(); start_stop = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1; cyc(); ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; cyc(); cyc();
    checks++;
    if ({val(), running, alarm, done} !== 19'h0)
      begin errors++; $display("FAIL reset_init: got %h/%b%b%b want 0000/000", val(), running, alarm, done); end
    rst = 1'b1;
    do_load(16'h1234);
    do_ss();
    checks++;
    if (running !== 1'b1 || val() !== 16'h1234)
      begin errors++; $display("FAIL reset_prerun: got %h run=%b want 1234 run=1", val(), running); end
    rst = 1'b0; cyc(); rst = 1'b1;
    checks++;
    if ({val(), running, alarm, done} !== 19'h0)
      begin errors++; $display("FAIL reset_midrun: got %h/%b%b%b want 0000/000", val(), running, alarm, done); end
  endtask

  task automatic test_minute();
    do_load(16'h0100);
    do_ss();
    do_tick();
    checks++;
    if (val() !== 16'h0059 || running !== 1'b1)
      begin errors++; $display("FAIL minute_first: got %h run=%b want 0059 run=1", val(), running); end
    for (int i = 0; i < 58; i++) do_tick();
    checks++;
    if (val() !== 16'h0001 || done !== 1'b0)
      begin errors++; $display("FAIL minute_pre: got %h done=%b want 0001 done=0", val(), done); end
    do_tick();
    checks++;
    if ({val(), done, alarm, running} !== {16'h0000, 3'b110})
      begin errors++; $display("FAIL minute_expire: got %h d/a/r=%b%b%b want 0000 110", val(), done, alarm, running); end
    cyc();
    checks++;
    if (done !== 1'b0 || alarm !== 1'b1)
      begin errors++; $display("FAIL minute_done_once: got done=%b alarm=%b want 0 1", done, alarm); end
    do_ack();
    checks++;
    if ({val(), alarm, running} !== {16'h0000, 2'b00})
      begin errors++; $display("FAIL ack_idle: got %h a/r=%b%b want 0000 00", val(), alarm, running); end
  endtask

  task automatic test_clamp_borrow();
    do_load(16'hAF7C);
    checks++;
    if (val() !== 16'h9959)
      begin errors++; $display("FAIL clamp: got %h want 9959", val()); end
    do_ss();
    do_tick();
    checks++;
    if (val() !== 16'h9958)
      begin errors++; $display("FAIL clamp_tick: got %h want 9958", val()); end
    do_ss();
    do_load(16'h1000);
    do_ss();
    do_tick();
    checks++;
    if (val() !== 16'h0959)
      begin errors++; $display("FAIL full_borrow: got %h want 0959", val()); end
  endtask

  task automatic test_pause();
    do_ss();
    do_load(16'h0000);
    do_ss();
    checks++;
    if (running !== 1'b0 || val() !== 16'h0000)
      begin errors++; $display("FAIL zero_start: got %h run=%b want 0000 run=0", val(), running); end
    do_load(16'h0010);
    do_ss();
    start_stop = 1'b1; tick = 1'b1; cyc(); start_stop = 1'b0; tick = 1'b0;
    checks++;
    if (running !== 1'b0 || val() !== 16'h0010)
      begin errors++; $display("FAIL ss_tick_pause: got %h run=%b want 0010 run=0", val(), running); end
    for (int i = 0; i < 3; i++) do_tick();
    checks++;
    if (val() !== 16'h0010)
      begin errors++; $display("FAIL pause_ticks: got %h want 0010", val()); end
    do_ss();
    do_tick();
    checks++;
    if (running !== 1'b1 || val() !== 16'h0009)
      begin errors++; $display("FAIL resume: got %h run=%b want 0009 run=1", val(), running); end
  endtask

  task automatic test_expired();
    do_ss();
    do_load(16'h0001);
    do_ss();
    do_tick();
    checks++;
    if (alarm !== 1'b1 || done !== 1'b1)
      begin errors++; $display("FAIL exp2: got alarm=%b done=%b want 1 1", alarm, done); end
    do_ss();
    checks++;
    if (alarm !== 1'b1 || running !== 1'b0)
      begin errors++; $display("FAIL exp_ss_ignored: got alarm=%b run=%b want 1 0", alarm, running); end
    {ld_min_t, ld_min_o, ld_sec_t, ld_sec_o} = 16'h0005;
    load = 1'b1; ack = 1'b1; cyc(); load = 1'b0; ack = 1'b0;
    checks++;
    if ({val(), alarm, running} !== {16'h0005, 2'b00})
      begin errors++; $display("FAIL load_ack: got %h a/r=%b%b want 0005 00", val(), alarm, running); end
    do_ss();
    do_load(16'h0300);
    checks++;
    if (val() !== 16'h0005 || running !== 1'b1)
      begin errors++; $display("FAIL load_in_run: got %h run=%b want 0005 run=1", val(), running); end
    do_tick();
    checks++;
    if (val() !== 16'h0004)
      begin errors++; $display("FAIL run_after_load: got %h want 0004", val()); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_v [3] = '{16'h0002, 16'h0001, 16'h0000};
    int done_cnt = 0;
    do_ss();
    do_load(16'h0003);
    do_ss();
    tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (done === 1'b1) done_cnt++;
      checks++;
      if (val() !== exp_v[(i < 2) ? i : 2])
        begin errors++; $display("FAIL b2b_val[%0d]: got %h want %h", i, val(), exp_v[(i < 2) ? i : 2]); end
    end
    tick = 1'b0;
    checks++;
    if (done_cnt != 1 || alarm !== 1'b1)
      begin errors++; $display("FAIL b2b_done: got done_cnt=%0d alarm=%b want 1 1", done_cnt, alarm); end
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; load = 1'b0; start_stop = 1'b0; ack = 1'b0;
    {ld_min_t, ld_min_o, ld_sec_t, ld_sec_o} = 16'h0;
    #2;
    test_reset();
    test_minute();
    test_clamp_borrow();
    test_pause();
    test_expired();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
